dmem_request_unit: RTL and testbench

Sequencing unit that consumes the decoder's per-instruction memory requests (`request_dmemREN`, `request_dmemWEN`, `halt_out`) and drives the cache-side request/hit handshake. It issues the instruction fetch, holds a data read or write until the cache answers, gates PC advance, and latches halt. It sits between the instruction decoder and the datapath/cache interface. It adds a data-access watchdog and an access counter for bring-up.

---
 rtl/dmem_request_unit.sv | 117 +++++++++++
 tb/tb_dmem_request_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_request_unit.sv
`default_nettype none
// ===========================================================================
// dmem_request_unit : fetch/data request sequencer with watchdog and counter
// Revision 1.0
// ===========================================================================
module dmem_request_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             request_dmemREN,
  input  logic             request_dmemWEN,
  input  logic             halt_in,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             busy,
  output logic             req_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] dacc_count
);

  localparam logic [1:0]  S_FETCH   = 2'd0;
  localparam logic [1:0]  S_DATA    = 2'd1;
  localparam logic [1:0]  S_HALTED  = 2'd2;
  localparam logic [16:0] C_TIMEOUT = {1'b0, 16'(TIMEOUT)};

  logic [1:0]  r_state;
  logic [15:0] r_wdog;

  logic        w_in_fetch;
  logic        w_in_data;
  logic        w_fetch_hit;
  logic        w_req_any;
  logic        w_data_done;
  logic [16:0] w_wdog_next;
  logic        w_wdog_sat;
  logic        w_cnt_sat;

  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_in_data   = (r_state == S_DATA);
  assign w_fetch_hit = w_in_fetch & ihit;
  assign w_req_any   = request_dmemREN | request_dmemWEN;
  assign w_data_done = w_in_data & dhit;
  assign w_wdog_next = {1'b0, r_wdog} + 17'd1;
  assign w_wdog_sat  = &r_wdog;
  assign w_cnt_sat   = &dacc_count;

  assign imemREN = w_in_fetch;
  assign busy    = w_in_data;
  assign pc_en   = (w_fetch_hit & ~halt_in & ~w_req_any) | w_data_done;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_FETCH;
      r_wdog      <= 16'd0;
      dmemREN     <= 1'b0;
      dmemWEN     <= 1'b0;
      halt        <= 1'b0;
      req_err     <= 1'b0;
      timeout_err <= 1'b0;
      dacc_count  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ihit) begin
            if (halt_in) begin
              r_state <= S_HALTED;
              halt    <= 1'b1;
            end else if (w_req_any) begin
              r_state <= S_DATA;
              r_wdog  <= 16'd0;
              // A store wins when the decoder flags both; the conflict is recorded.
              dmemWEN <= request_dmemWEN;
              dmemREN <= request_dmemREN & ~request_dmemWEN;
              if (request_dmemREN & request_dmemWEN) begin
                req_err <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (dhit) begin
            r_state <= S_FETCH;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            if (!w_cnt_sat) begin
              dacc_count <= dacc_count + 1'b1;
            end
          end else begin
            if (!w_wdog_sat) begin
              r_wdog <= w_wdog_next[15:0];
            end
            if (w_wdog_next >= C_TIMEOUT) begin
              timeout_err <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_FETCH;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_request_unit.sv
`default_nettype none
// ===========================================================================
// tb_dmem_request_unit : directed and random stimulus against a transaction model
// Revision 1.0
// ===========================================================================
module tb_dmem_request_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             nRST, ihit, dhit, request_dmemREN, request_dmemWEN, halt_in;
  logic             imemREN, dmemREN, dmemWEN, pc_en, halt, busy, req_err, timeout_err;
  logic [CNT_W-1:0] dacc_count;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level view: is the core halted, which data op is in flight,
  // how long it has waited, and the accumulated sticky/counter observations.
  bit m_halted;
  int m_op;      // 0 none, 1 load, 2 store
  int m_wait;
  bit m_tout;
  bit m_rerr;
  int m_cnt;

  dmem_request_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .request_dmemREN(request_dmemREN), .request_dmemWEN(request_dmemWEN),
    .halt_in(halt_in), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt), .busy(busy), .req_err(req_err),
    .timeout_err(timeout_err), .dacc_count(dacc_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!nRST) begin
      m_halted = 0; m_op = 0; m_wait = 0; m_tout = 0; m_rerr = 0; m_cnt = 0;
    end else if (m_halted) begin
    end else if (m_op == 0) begin
      if (ihit) begin
        if (halt_in) m_halted = 1;
        else if (request_dmemWEN) begin
          m_op = 2; m_wait = 0;
          if (request_dmemREN) m_rerr = 1;
        end else if (request_dmemREN) begin
          m_op = 1; m_wait = 0;
        end
      end
    end else begin
      if (dhit) begin
        m_op = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_tout = 1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_pc;
    exp_pc = (!m_halted && m_op == 0 && ihit && !halt_in && !request_dmemREN && !request_dmemWEN)
             || (m_op != 0 && dhit);
    check("imemREN",     32'(imemREN),     32'(!m_halted && m_op == 0));
    check("busy",        32'(busy),        32'(m_op != 0));
    check("dmemREN",     32'(dmemREN),     32'(m_op == 1));
    check("dmemWEN",     32'(dmemWEN),     32'(m_op == 2));
    check("pc_en",       32'(pc_en),       32'(exp_pc));
    check("halt",        32'(halt),        32'(m_halted));
    check("req_err",     32'(req_err),     32'(m_rerr));
    check("timeout_err", 32'(timeout_err), 32'(m_tout));
    check("dacc_count",  32'(dacc_count),  32'(m_cnt));
  endtask

  // Apply one cycle of inputs: model and DUT both consume the previous inputs at the edge.
  task automatic cyc(input bit rn, input bit ih, input bit dh,
                     input bit rr, input bit rw, input bit hi);
    @(posedge CLK);
    model_step();
    #1;
    nRST = rn; ihit = ih; dhit = dh;
    request_dmemREN = rr; request_dmemWEN = rw; halt_in = hi;
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    int ren_cycles;
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
    request_dmemREN = 1'b0; request_dmemWEN = 1'b0; halt_in = 1'b0;

    // reset, then ALU-only stream
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0);
    check("alu_count_zero", 32'(dacc_count), 32'd0);

    // load with three wait cycles: dmemREN high for exactly 4 cycles
    cyc(1, 1, 0, 1, 0, 0);
    ren_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      if (dmemREN) ren_cycles++;
    end
    cyc(1, 0, 1, 0, 0, 0);
    if (dmemREN) ren_cycles++;
    check("load_pc_on_dhit", 32'(pc_en), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("load_ren_cycles", 32'(ren_cycles), 32'd4);
    check("load_count", 32'(dacc_count), 32'd1);

    // store with both request bits: WEN wins, req_err sticks
    cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("req_err_sticky", 32'(req_err), 32'd1);

    // watchdog: dhit low 10 cycles, then completes
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // zero-wait accesses up to and past counter saturation
    for (int i = 0; i < 18; i++) begin
      cyc(1, 1, 0, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    check("count_saturated", 32'(dacc_count), 32'(CNT_MAX));

    // halt with a store request, then inputs are ignored
    cyc(1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 1, 0);
    check("halted_sticky", 32'(halt), 32'd1);

    // reset mid-DATA; following dhit is ignored
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_drops_req", 32'(dacc_count), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) != 0), ($urandom_range(1) == 1), ($urandom_range(2) == 0),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
